div_iter: RTL and testbench

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage. It replaces the single-cycle combinational divide path.
- Consumes the same rs/rt operands the ALU receives. Produces the 64-bit {remainder, quotient} word that the HI/LO write path consumes, with HI = remainder and LO = quotient.
- Drives a stall to the pipeline controller while a divide is in flight.

---
 rtl/div_iter.sv | 166 ++++++++++++++++
 tb/tb_div_iter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//            Produces {remainder, quotient} and stalls EX while in flight.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH    = 32,
    parameter int ZERO_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] result,
    output logic               valid,
    output logic               busy,
    output logic               stall
);

    localparam int c_CMAX = (WIDTH > ZERO_LAT) ? WIDTH : ZERO_LAT;
    localparam int c_CW   = (c_CMAX > 2) ? $clog2(c_CMAX) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ZLAST = c_CW'((ZERO_LAT > 1) ? ZERO_LAT - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_div;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_fin;
    logic                 r_zero;
    logic                 r_valid_seen;

    logic                 w_idle;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH+1:0]     w_sub;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quot;
    logic [2*WIDTH-1:0]   w_fix;

    assign w_idle  = (r_state == S_IDLE);
    assign w_abs_a = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Upper WIDTH+1 bits of the shifted {rem, quot}; the extra top bit of the
    // subtract exposes the borrow so a negative trial is detected.
    assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_sub   = {1'b0, w_shift} - {2'b00, r_div};
    assign w_ge    = (w_sub[WIDTH+1:WIDTH] == 2'b00);
    assign w_step  = w_ge ? {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                          : {r_acc[2*WIDTH-2:0], 1'b0};

    assign w_rem   = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot  = r_acc[WIDTH-1:0];
    assign w_fix   = {r_neg_r ? (~w_rem + 1'b1) : w_rem,
                      r_neg_q ? (~w_quot + 1'b1) : w_quot};

    assign busy  = ~w_idle;
    assign stall = (start & w_idle & ~cancel)
                 | (r_state == S_BUSY)
                 | ((r_state == S_DONE) & ~r_valid_seen);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_div        <= '0;
            r_cnt        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_fin        <= 1'b0;
            r_zero       <= 1'b0;
            r_valid_seen <= 1'b0;
            result       <= '0;
            valid        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    valid <= 1'b0;
                    if (start && !cancel) begin
                        r_cnt <= '0;
                        r_fin <= 1'b0;
                        if (b == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            if (ZERO_LAT <= 1) begin
                                r_state      <= S_DONE;
                                result       <= {a, {WIDTH{1'b1}}};
                                valid        <= 1'b1;
                                r_valid_seen <= 1'b0;
                            end else begin
                                r_state <= S_BUSY;
                                r_zero  <= 1'b1;
                                r_acc   <= {a, {WIDTH{1'b1}}};
                            end
                        end else begin
                            r_state <= S_BUSY;
                            r_zero  <= 1'b0;
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                            r_div   <= w_abs_b;
                            r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= sign & a[WIDTH-1];
                        end
                    end
                end

                S_BUSY: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_zero  <= 1'b0;
                    end else if (r_zero) begin
                        if (r_cnt == c_ZLAST) begin
                            r_state      <= S_DONE;
                            r_zero       <= 1'b0;
                            result       <= r_acc;
                            valid        <= 1'b1;
                            r_valid_seen <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_fin) begin
                        r_state      <= S_DONE;
                        result       <= w_fix;
                        valid        <= 1'b1;
                        r_valid_seen <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt == c_LAST) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state      <= S_IDLE;
                    valid        <= 1'b0;
                    r_valid_seen <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Directed self-checking bench for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [63:0] result;
    logic        valid;
    logic        busy;
    logic        stall;

    int n_tests;
    int n_fail;

    div_iter #(
        .WIDTH    (32),
        .ZERO_LAT (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .result (result),
        .valid  (valid),
        .busy   (busy),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, counts edges after the accept edge until valid, and
    // checks latency, result, busy/stall coverage and the one-cycle pulse.
    task automatic do_div(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          input int lat, input logic [63:0] exp_res, input string tag);
        int  n;
        logic hold_ok;
        n       = 0;
        hold_ok = 1'b1;
        sign  = s;
        a     = aa;
        b     = bb;
        start = 1'b1;
        #1;
        check({tag, "_stall_start"}, stall, 1);
        tick();
        start = 1'b0;
        while (!valid && n < 40) begin
            if (!busy || !stall) hold_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_stall_hold"}, hold_ok, 1);
        check({tag, "_done_busy_stall"}, {busy, stall}, 2'b11);
        tick();
        check({tag, "_valid_drop"}, {valid, busy}, 2'b00);
    endtask

    initial begin
        int n;
        int vcount;
        logic [63:0] r_first;

        n_tests = 0;
        n_fail  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        sign   = 1'b0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;

        #12;
        check("reset_state", {result, valid, busy, stall}, 67'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        do_div(1'b0, 32'd100, 32'd7, 33, 64'h0000_0002_0000_000E, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, 64'h0000_0001_FFFF_FFFD, "div_7_m2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, "div_ovf");
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h8000_0000_0000_0000, "divu_big");
        do_div(1'b0, 32'd5, 32'd0, 0, 64'h0000_0005_FFFF_FFFF, "div_zero");

        // Cancel at iteration 10: no valid, result retains the div-by-zero value.
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_idle", {busy, valid}, 2'b00);
        check("cancel_result_kept", result, 64'h0000_0005_FFFF_FFFF);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) vcount++;
            tick();
        end
        check("cancel_no_valid", vcount, 0);
        do_div(1'b0, 32'd9, 32'd3, 33, 64'h0000_0000_0000_0003, "after_cancel");

        // Asynchronous reset in the middle of BUSY.
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {result, valid, busy, stall}, 67'd0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) vcount++;
            tick();
        end
        check("reset_no_valid", vcount, 0);
        do_div(1'b0, 32'd100, 32'd7, 33, 64'h0000_0002_0000_000E, "after_reset");

        // Start pulses during BUSY must be ignored.
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        a = 32'd9;
        b = 32'd3;
        n = 0;
        vcount = 0;
        r_first = '0;
        while (n < 40 && vcount == 0) begin
            start = (n % 3 == 0);
            tick();
            n++;
            if (valid) begin
                vcount++;
                r_first = result;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ignore_start_latency", n, 33);
        check("ignore_start_result", r_first, 64'h0000_0002_0000_000E);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("ignore_start_one_valid", vcount, 1);

        // Back-to-back: second op is accepted on the IDLE cycle right after DONE.
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 33, 64'hFFFF_FFFE_FFFF_FFF2, "b2b_first");
        do_div(1'b0, 32'd9, 32'd3, 33, 64'h0000_0000_0000_0003, "b2b_second");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
